// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: matrix row/column lines plus the decoded key and digit buffer.
// The scanner drives through the master modport; the keypad/consumer side uses slave.
interface keypad_scanner_if;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key;
  logic        key_valid;
  logic [15:0] key_buffer;
  logic [2:0]  buffer_cnt;

  modport master (
    input  row_n,
    output col_n, key, key_valid, key_buffer, buffer_cnt
  );

  modport slave (
    output row_n,
    input  col_n, key, key_valid, key_buffer, buffer_cnt
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce, one key code per press,
// and a 4-digit shift buffer feeding the time/alarm load logic.
module keypad_scanner #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic              clock,
  input  logic              reset,
  keypad_scanner_if.master  kp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] KEY_IDLE  = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hE;
  localparam logic [2:0] ARMED     = 3'd4;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  function automatic logic [3:0] decode_key(input logic [3:0] pat, input logic [1:0] col);
    logic [1:0] r;
    logic [3:0] code;
    case (pat)
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      4'b0111: r = 2'd3;
      default: r = 2'd0;
    endcase
    case ({r, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] cnt);
    return (cnt >= 3'd4) ? 3'd4 : cnt + 3'd1;
  endfunction

  logic [3:0]       row_meta_q, row_s_q;
  state_t           state_q, state_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]       row_pat_q, row_pat_d;
  logic [3:0]       key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic [15:0]      key_buffer_q, key_buffer_d;
  logic [2:0]       buffer_cnt_q, buffer_cnt_d;
  logic [2:0]       idle_cnt_q, idle_cnt_d;
  logic [3:0]       code;
  int               lows;

  // Two-flop synchronizer for the asynchronous keypad rows
  always_ff @(posedge clock) begin
    row_meta_q <= kp.row_n;
    row_s_q    <= row_meta_q;
  end

  assign code = decode_key(row_pat_q, col_idx_q);
  assign lows = $countones(~row_s_q);

  always_comb begin
    state_d      = state_q;
    col_idx_d    = col_idx_q;
    div_cnt_d    = div_cnt_q;
    deb_cnt_d    = deb_cnt_q;
    row_pat_d    = row_pat_q;
    key_d        = key_q;
    key_valid_d  = 1'b0;
    key_buffer_d = key_buffer_q;
    buffer_cnt_d = buffer_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    case (state_q)
      SCAN: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          deb_cnt_d = '0;
          // Until a full idle rotation (or a release) is seen after reset, a key
          // already held is treated as stale and only waited out.
          if (lows == 1 && idle_cnt_q == ARMED) begin
            row_pat_d = row_s_q;
            state_d   = DEBOUNCE;
          end else if (lows != 0) begin
            state_d = RELEASE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
            if (idle_cnt_q != ARMED) idle_cnt_d = idle_cnt_q + 3'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      DEBOUNCE: begin
        if (row_s_q != row_pat_q) begin
          state_d   = SCAN;
          div_cnt_d = '0;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = PRESSED;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      PRESSED: begin
        key_d       = code;
        key_valid_d = 1'b1;
        deb_cnt_d   = '0;
        state_d     = RELEASE;
        if (code <= 4'd9) begin
          key_buffer_d = {key_buffer_q[11:0], code};
          buffer_cnt_d = sat_inc(buffer_cnt_q);
        end else if (code == KEY_CLEAR) begin
          key_buffer_d = '0;
          buffer_cnt_d = '0;
        end
      end
      default: begin
        if (row_s_q != 4'b1111) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d    = SCAN;
          key_d      = KEY_IDLE;
          div_cnt_d  = '0;
          deb_cnt_d  = '0;
          idle_cnt_d = ARMED;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= SCAN;
      col_idx_q    <= '0;
      div_cnt_q    <= '0;
      deb_cnt_q    <= '0;
      row_pat_q    <= 4'b1111;
      key_q        <= KEY_IDLE;
      key_valid_q  <= 1'b0;
      key_buffer_q <= '0;
      buffer_cnt_q <= '0;
      idle_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      col_idx_q    <= col_idx_d;
      div_cnt_q    <= div_cnt_d;
      deb_cnt_q    <= deb_cnt_d;
      row_pat_q    <= row_pat_d;
      key_q        <= key_d;
      key_valid_q  <= key_valid_d;
      key_buffer_q <= key_buffer_d;
      buffer_cnt_q <= buffer_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

  assign kp.col_n      = ~(4'b0001 << col_idx_q);
  assign kp.key        = key_q;
  assign kp.key_valid  = key_valid_q;
  assign kp.key_buffer = key_buffer_q;
  assign kp.buffer_cnt = buffer_cnt_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a switch-matrix model drives row_n from col_n
// and the set of pressed keys; each scenario task checks its own expectations.
module tb_keypad_scanner;
  logic        clock;
  logic        reset;
  logic [15:0] pressed;
  logic        force_low;
  logic [3:0]  matrix_rows;
  int          checks;
  int          errors;
  int          vcnt;
  logic [3:0]  last_key;

  keypad_scanner_if kif ();

  keypad_scanner #(.SCAN_DIV(16), .DEBOUNCE_CYCLES(8)) dut (
    .clock (clock),
    .reset (reset),
    .kp    (kif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    matrix_rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kif.col_n[c]) matrix_rows[r] = 1'b0;
  end
  assign kif.row_n = force_low ? 4'b0000 : matrix_rows;

  always @(negedge clock) begin
    if (kif.key_valid === 1'b1) begin
      vcnt     <= vcnt + 1;
      last_key <= kif.key;
    end
  end

  task automatic press_key(input int r, input int c, input int hold);
    @(negedge clock);
    pressed[r*4+c] = 1'b1;
    repeat (hold) @(negedge clock);
    pressed = '0;
    repeat (40) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    force_low = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (kif.col_n !== 4'b1110) begin errors++; $display("FAIL reset_col_n: got %b expected 1110", kif.col_n); end
    checks++; if (kif.key !== 4'hA) begin errors++; $display("FAIL reset_key: got %h expected a", kif.key); end
    checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b expected 0", kif.key_valid); end
    checks++; if (kif.key_buffer !== 16'h0000) begin errors++; $display("FAIL reset_key_buffer: got %h expected 0000", kif.key_buffer); end
    checks++; if (kif.buffer_cnt !== 3'd0) begin errors++; $display("FAIL reset_buffer_cnt: got %0d expected 0", kif.buffer_cnt); end
    reset = 1'b0;
    force_low = 1'b0;
    repeat (100) @(negedge clock);
  endtask

  task automatic test_single_press();
    int v0;
    v0 = vcnt;
    @(negedge clock);
    pressed[1*4+1] = 1'b1;
    repeat (150) @(negedge clock);
    checks++; if (kif.key !== 4'h5) begin errors++; $display("FAIL single_key_held: got %h expected 5", kif.key); end
    repeat (50) @(negedge clock);
    pressed = '0;
    repeat (40) @(negedge clock);
    checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL single_valid_count: got %0d expected 1", vcnt - v0); end
    checks++; if (last_key !== 4'h5) begin errors++; $display("FAIL single_last_key: got %h expected 5", last_key); end
    checks++; if (kif.key_buffer !== 16'h0005) begin errors++; $display("FAIL single_buffer: got %h expected 0005", kif.key_buffer); end
    checks++; if (kif.buffer_cnt !== 3'd1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", kif.buffer_cnt); end
    checks++; if (kif.key !== 4'hA) begin errors++; $display("FAIL single_key_released: got %h expected a", kif.key); end
  endtask

  task automatic test_bounce();
    int v0;
    v0 = vcnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      pressed[0*4+2] = ~pressed[0*4+2];
      repeat (2) @(negedge clock);
    end
    checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL bounce_no_valid: got %0d expected 0", vcnt - v0); end
    pressed[0*4+2] = 1'b1;
    repeat (200) @(negedge clock);
    pressed = '0;
    repeat (40) @(negedge clock);
    checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL bounce_valid_count: got %0d expected 1", vcnt - v0); end
    checks++; if (last_key !== 4'h3) begin errors++; $display("FAIL bounce_key: got %h expected 3", last_key); end
    checks++; if (kif.key_buffer !== 16'h0053) begin errors++; $display("FAIL bounce_buffer: got %h expected 0053", kif.key_buffer); end
  endtask

  task automatic test_buffer_overflow_clear();
    press_key(0, 0, 200);
    press_key(0, 1, 200);
    press_key(0, 2, 200);
    press_key(1, 0, 200);
    press_key(2, 2, 200);
    checks++; if (kif.key_buffer !== 16'h2349) begin errors++; $display("FAIL overflow_buffer: got %h expected 2349", kif.key_buffer); end
    checks++; if (kif.buffer_cnt !== 3'd4) begin errors++; $display("FAIL overflow_cnt: got %0d expected 4", kif.buffer_cnt); end
    press_key(3, 0, 200);
    checks++; if (last_key !== 4'hE) begin errors++; $display("FAIL clear_key: got %h expected e", last_key); end
    checks++; if (kif.key_buffer !== 16'h0000) begin errors++; $display("FAIL clear_buffer: got %h expected 0000", kif.key_buffer); end
    checks++; if (kif.buffer_cnt !== 3'd0) begin errors++; $display("FAIL clear_cnt: got %0d expected 0", kif.buffer_cnt); end
  endtask

  task automatic test_non_digit();
    int v0;
    press_key(2, 1, 200);
    checks++; if (kif.key_buffer !== 16'h0008) begin errors++; $display("FAIL nondigit_pre_buffer: got %h expected 0008", kif.key_buffer); end
    v0 = vcnt;
    press_key(3, 2, 200);
    checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL hash_valid_count: got %0d expected 1", vcnt - v0); end
    checks++; if (last_key !== 4'hF) begin errors++; $display("FAIL hash_key: got %h expected f", last_key); end
    press_key(1, 3, 200);
    checks++; if (vcnt - v0 !== 2) begin errors++; $display("FAIL b_valid_count: got %0d expected 2", vcnt - v0); end
    checks++; if (last_key !== 4'hB) begin errors++; $display("FAIL b_key: got %h expected b", last_key); end
    checks++; if (kif.key_buffer !== 16'h0008) begin errors++; $display("FAIL nondigit_buffer: got %h expected 0008", kif.key_buffer); end
    checks++; if (kif.buffer_cnt !== 3'd1) begin errors++; $display("FAIL nondigit_cnt: got %0d expected 1", kif.buffer_cnt); end
  endtask

  task automatic test_multi_key();
    int v0;
    v0 = vcnt;
    @(negedge clock);
    pressed[0*4+0] = 1'b1;
    pressed[1*4+0] = 1'b1;
    repeat (200) @(negedge clock);
    checks++; if (kif.key !== 4'hA) begin errors++; $display("FAIL multi_key_idle: got %h expected a", kif.key); end
    pressed = '0;
    repeat (40) @(negedge clock);
    checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL multi_no_valid: got %0d expected 0", vcnt - v0); end
  endtask

  task automatic test_reset_mid_press();
    int v0;
    int n;
    bit ok;
    v0 = vcnt;
    ok = 1'b0;
    n = 0;
    // Align to the first cycle of column 0 so the DEBOUNCE window is known.
    while (kif.col_n == 4'b1110 && n < 200) begin @(negedge clock); n++; end
    while (kif.col_n != 4'b1110 && n < 200) begin @(negedge clock); n++; end
    if (n < 200) ok = 1'b1;
    checks++; if (!ok) begin errors++; $display("FAIL col0_align: got timeout after %0d cycles expected col_n 1110", n); end
    pressed[2*4+0] = 1'b1;
    repeat (18) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (kif.key_buffer !== 16'h0000) begin errors++; $display("FAIL midreset_buffer: got %h expected 0000", kif.key_buffer); end
    repeat (200) @(negedge clock);
    checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL midreset_no_valid: got %0d expected 0", vcnt - v0); end
    checks++; if (kif.key !== 4'hA) begin errors++; $display("FAIL midreset_key: got %h expected a", kif.key); end
    pressed = '0;
    repeat (40) @(negedge clock);
    press_key(2, 0, 200);
    checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL repress_valid_count: got %0d expected 1", vcnt - v0); end
    checks++; if (last_key !== 4'h7) begin errors++; $display("FAIL repress_key: got %h expected 7", last_key); end
    checks++; if (kif.key_buffer !== 16'h0007) begin errors++; $display("FAIL repress_buffer: got %h expected 0007", kif.key_buffer); end
    checks++; if (kif.buffer_cnt !== 3'd1) begin errors++; $display("FAIL repress_cnt: got %0d expected 1", kif.buffer_cnt); end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    vcnt = 0;
    last_key = 4'h0;
    pressed = '0;
    force_low = 1'b0;
    reset = 1'b1;
    test_reset();
    test_single_press();
    test_bounce();
    test_buffer_overflow_clear();
    test_non_digit();
    test_multi_key();
    test_reset_mid_press();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
